// File: rtl/mem_seq_pkg.sv
// Shared types for mem_seq: access-size encoding, FSM states and size helpers.
package mem_seq_pkg;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StWr   = 2'd2,
    StDone = 2'd3
  } state_e;

  // Value of the read step counter at the edge that captures the last byte.
  localparam logic [2:0] RdLastCnt = 3'd4;

  function automatic logic [2:0] size_bytes(size_e sz);
    logic [2:0] n;
    unique case (sz)
      SZ_NONE: n = 3'd0;
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_seq.sv
// Sequences 32-bit CPU reads and 8/16/32-bit writes onto a byte-wide registered RAM.
// Optional MEM_SEQ_ALIGN_CHECK_EN adds m_err and rejects misaligned half/word accesses.
module mem_seq
  import mem_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
`ifdef MEM_SEQ_ALIGN_CHECK_EN
  output logic              m_err,
`endif
  input  logic              clk,
  input  logic              reset,
  input  logic              m_in_req,
  input  logic [ADDR_W-1:0] m_in_addr,
  output logic [31:0]       m_in_data,
  output logic              m_in_ready,
  input  logic [1:0]        m_out_sig_write,
  input  logic [ADDR_W-1:0] m_out_addr,
  input  logic [31:0]       m_out_data,
  output logic              m_out_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  state_e            r_state, w_state;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic              r_we, w_we;
  logic [7:0]        r_wdata, w_wdata;
  logic [31:0]       r_buf, w_buf;
  logic [31:0]       r_rdata, w_rdata;
  logic [2:0]        r_cnt, w_cnt;
  logic [2:0]        r_nbytes, w_nbytes;
  logic              r_in_ready, w_in_ready;
  logic              r_out_ready, w_out_ready;
  size_e             w_size;
  logic              w_wr_misalign, w_rd_misalign;

  assign w_size = size_e'(m_out_sig_write);

`ifdef MEM_SEQ_ALIGN_CHECK_EN
  logic r_err, w_err;
  assign w_wr_misalign = ((w_size == SZ_HALF) && m_out_addr[0]) ||
                         ((w_size == SZ_WORD) && (m_out_addr[1:0] != 2'b00));
  assign w_rd_misalign = (m_in_addr[1:0] != 2'b00);
  assign m_err         = r_err;
`else
  assign w_wr_misalign = 1'b0;
  assign w_rd_misalign = 1'b0;
`endif

  always_comb begin
    w_state     = r_state;
    w_addr      = r_addr;
    w_we        = 1'b0;
    w_wdata     = r_wdata;
    w_buf       = r_buf;
    w_rdata     = r_rdata;
    w_cnt       = r_cnt;
    w_nbytes    = r_nbytes;
    w_in_ready  = 1'b0;
    w_out_ready = 1'b0;
`ifdef MEM_SEQ_ALIGN_CHECK_EN
    w_err       = 1'b0;
`endif
    unique case (r_state)
      StIdle: begin
        // Writes take priority; a coincident read waits for the next idle cycle.
        if (w_size != SZ_NONE) begin
          if (w_wr_misalign) begin
            w_state     = StDone;
            w_out_ready = 1'b1;
`ifdef MEM_SEQ_ALIGN_CHECK_EN
            w_err       = 1'b1;
`endif
          end else begin
            w_state  = StWr;
            w_we     = 1'b1;
            w_addr   = m_out_addr;
            w_wdata  = m_out_data[7:0];
            w_buf    = {8'h00, m_out_data[31:8]};
            w_cnt    = 3'd1;
            w_nbytes = size_bytes(w_size);
          end
        end else if (m_in_req) begin
          if (w_rd_misalign) begin
            w_state    = StDone;
            w_in_ready = 1'b1;
`ifdef MEM_SEQ_ALIGN_CHECK_EN
            w_err      = 1'b1;
`endif
          end else begin
            w_state = StRd;
            w_addr  = m_in_addr;
            w_cnt   = 3'd0;
          end
        end
      end
      StRd: begin
        // RAM data lags the address by one cycle; bytes shift in from the top.
        if (r_cnt != 3'd0) w_buf = {ram_rdata, r_buf[31:8]};
        if (r_cnt < 3'd3) w_addr = r_addr + ADDR_W'(1);
        if (r_cnt == RdLastCnt) begin
          w_rdata    = w_buf;
          w_in_ready = 1'b1;
          w_state    = StDone;
        end else begin
          w_cnt = r_cnt + 3'd1;
        end
      end
      StWr: begin
        if (r_cnt == r_nbytes) begin
          w_out_ready = 1'b1;
          w_state     = StDone;
        end else begin
          w_we    = 1'b1;
          w_addr  = r_addr + ADDR_W'(1);
          w_wdata = r_buf[7:0];
          w_buf   = {8'h00, r_buf[31:8]};
          w_cnt   = r_cnt + 3'd1;
        end
      end
      StDone:  w_state = StIdle;
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= 8'h00;
      r_buf       <= 32'h0;
      r_rdata     <= 32'h0;
      r_cnt       <= 3'd0;
      r_nbytes    <= 3'd0;
      r_in_ready  <= 1'b0;
      r_out_ready <= 1'b0;
`ifdef MEM_SEQ_ALIGN_CHECK_EN
      r_err       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state;
      r_addr      <= w_addr;
      r_we        <= w_we;
      r_wdata     <= w_wdata;
      r_buf       <= w_buf;
      r_rdata     <= w_rdata;
      r_cnt       <= w_cnt;
      r_nbytes    <= w_nbytes;
      r_in_ready  <= w_in_ready;
      r_out_ready <= w_out_ready;
`ifdef MEM_SEQ_ALIGN_CHECK_EN
      r_err       <= w_err;
`endif
    end
  end

  assign m_in_data   = r_rdata;
  assign m_in_ready  = r_in_ready;
  assign m_out_ready = r_out_ready;
  assign ram_addr    = r_addr;
  assign ram_we      = r_we;
  assign ram_wdata   = r_wdata;

endmodule

// File: tb/tb_mem_seq.sv
// Directed bench for mem_seq: byte-RAM model, read-data scoreboard and latency checks.
module tb_mem_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_in_req;
  logic [7:0]  m_in_addr;
  logic [31:0] m_in_data;
  logic        m_in_ready;
  logic [1:0]  m_out_sig_write;
  logic [7:0]  m_out_addr;
  logic [31:0] m_out_data;
  logic        m_out_ready;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
`ifdef MEM_SEQ_ALIGN_CHECK_EN
  logic        m_err;
`endif

  int checks   = 0;
  int failures = 0;
  int we_cnt   = 0;
  int both_cnt = 0;
  int lat;
  int we_base;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;

  logic [7:0] mem [256];
  logic       pre_we = 1'b0;
  logic [7:0] pre_addr = 8'h00;
  logic [7:0] pre_data = 8'h00;

  mem_seq #(.ADDR_W(8)) dut (
`ifdef MEM_SEQ_ALIGN_CHECK_EN
    .m_err          (m_err),
`endif
    .clk            (clk),
    .reset          (reset),
    .m_in_req       (m_in_req),
    .m_in_addr      (m_in_addr),
    .m_in_data      (m_in_data),
    .m_in_ready     (m_in_ready),
    .m_out_sig_write(m_out_sig_write),
    .m_out_addr     (m_out_addr),
    .m_out_data     (m_out_data),
    .m_out_ready    (m_out_ready),
    .ram_addr       (ram_addr),
    .ram_we         (ram_we),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata)
  );

  always #5 clk = ~clk;

  // Registered-read byte RAM with a side port for preloading.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (ram_we) we_cnt++;
    if (m_in_ready && m_out_ready) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  // Counts edges until the selected ready is seen; gives up after 30.
  task automatic wait_rdy(input bit is_read, output int n);
    n = 0;
    while (!(is_read ? m_in_ready : m_out_ready) && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic do_read(input string tag, input logic [7:0] a, input logic [31:0] exp);
    int l;
    exp_q.push_back(exp);
    we_base   = we_cnt;
    m_in_req  = 1'b1;
    m_in_addr = a;
    tick();
    wait_rdy(1'b1, l);
    check({tag, "_lat"}, 32'(l), 32'd5);
    check({tag, "_wrrdy"}, {31'd0, m_out_ready}, 32'd0);
    m_in_req = 1'b0;
    exp_w = exp_q.pop_front();
    check({tag, "_data"}, m_in_data, exp_w);
    check({tag, "_nowe"}, 32'(we_cnt - we_base), 32'd0);
    tick();
  endtask

  task automatic do_write(input string tag, input logic [1:0] sz, input logic [7:0] a,
                          input logic [31:0] d, input int nb);
    int l;
    we_base         = we_cnt;
    m_out_sig_write = sz;
    m_out_addr      = a;
    m_out_data      = d;
    tick();
    wait_rdy(1'b0, l);
    check({tag, "_lat"}, 32'(l), 32'(nb));
    check({tag, "_rdrdy"}, {31'd0, m_in_ready}, 32'd0);
    m_out_sig_write = 2'd0;
    check({tag, "_wecnt"}, 32'(we_cnt - we_base), 32'(nb));
    tick();
  endtask

  initial begin
    reset           = 1'b1;
    m_in_req        = 1'b0;
    m_in_addr       = 8'h00;
    m_out_sig_write = 2'd0;
    m_out_addr      = 8'h00;
    m_out_data      = 32'h0;
    poke(8'h10, 8'h11); poke(8'h11, 8'h22); poke(8'h12, 8'h33); poke(8'h13, 8'h44);
    poke(8'h09, 8'h55); poke(8'h0A, 8'h66); poke(8'h0B, 8'h77);
    poke(8'h05, 8'hA5); poke(8'h06, 8'hB6); poke(8'h07, 8'hC7);
    poke(8'h30, 8'h00); poke(8'h31, 8'h5A); poke(8'h32, 8'h5A); poke(8'h33, 8'h5A);

    check("rst_in_data", m_in_data, 32'h0);
    check("rst_in_ready", {31'd0, m_in_ready}, 32'd0);
    check("rst_out_ready", {31'd0, m_out_ready}, 32'd0);
    check("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
    reset = 1'b0;
    tick();

    do_read("rd10", 8'h10, 32'h44332211);

    do_write("wr20", 2'd3, 8'h20, 32'hDEADBEEF, 4);
    check("wr20_b0", {24'd0, mem[8'h20]}, 32'hEF);
    check("wr20_b1", {24'd0, mem[8'h21]}, 32'hBE);
    check("wr20_b2", {24'd0, mem[8'h22]}, 32'hAD);
    check("wr20_b3", {24'd0, mem[8'h23]}, 32'hDE);
    check("hold_in_data", m_in_data, 32'h44332211);

    do_write("wr40", 2'd2, 8'h40, 32'h00001234, 2);
    check("wr40_b0", {24'd0, mem[8'h40]}, 32'h34);
    check("wr40_b1", {24'd0, mem[8'h41]}, 32'h12);

    do_read("rd20", 8'h20, 32'hDEADBEEF);

    // Coincident read and byte write: write first, read then sees the new byte.
    exp_q.push_back(32'h776655AB);
    m_in_req        = 1'b1;
    m_in_addr       = 8'h08;
    m_out_sig_write = 2'd1;
    m_out_addr      = 8'h08;
    m_out_data      = 32'h000000AB;
    tick();
    wait_rdy(1'b0, lat);
    check("coll_wr_lat", 32'(lat), 32'd1);
    check("coll_no_rd", {31'd0, m_in_ready}, 32'd0);
    m_out_sig_write = 2'd0;
    wait_rdy(1'b1, lat);
    check("coll_rd_lat", 32'(lat), 32'd7);
    m_in_req = 1'b0;
    exp_w = exp_q.pop_front();
    check("coll_rd_data", m_in_data, exp_w);
    tick();

`ifndef MEM_SEQ_ALIGN_CHECK_EN
    do_write("wrFE", 2'd3, 8'hFE, 32'h01020304, 4);
    check("wrFE_b0", {24'd0, mem[8'hFE]}, 32'h04);
    check("wrFE_b1", {24'd0, mem[8'hFF]}, 32'h03);
    check("wrFE_b2", {24'd0, mem[8'h00]}, 32'h02);
    check("wrFE_b3", {24'd0, mem[8'h01]}, 32'h01);
    do_read("rdFE", 8'hFE, 32'h01020304);
    do_read("rd05", 8'h05, 32'hABC7B6A5);
`else
    we_base   = we_cnt;
    m_in_req  = 1'b1;
    m_in_addr = 8'h05;
    tick();
    wait_rdy(1'b1, lat);
    check("mis_lat", 32'(lat), 32'd0);
    check("mis_err", {31'd0, m_err}, 32'd1);
    check("mis_data", m_in_data, 32'h776655AB);
    m_in_req = 1'b0;
    tick();
    check("mis_err_clr", {31'd0, m_err}, 32'd0);
    check("mis_nowe", 32'(we_cnt - we_base), 32'd0);
    tick();
`endif

    // Reset sampled at the edge that would issue byte 1 of a word write.
    m_out_sig_write = 2'd3;
    m_out_addr      = 8'h30;
    m_out_data      = 32'hCAFEF00D;
    tick();
    reset = 1'b1;
    tick();
    m_out_sig_write = 2'd0;
    check("rstmid_in_data", m_in_data, 32'h0);
    check("rstmid_we", {31'd0, ram_we}, 32'd0);
    check("rstmid_addr", {24'd0, ram_addr}, 32'd0);
    check("rstmid_wdata", {24'd0, ram_wdata}, 32'd0);
    check("rstmid_rdys", {30'd0, m_in_ready, m_out_ready}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rstmid_norp", {30'd0, m_in_ready, m_out_ready}, 32'd0);
    end
    check("rstmid_b0", {24'd0, mem[8'h30]}, 32'h0D);
    check("rstmid_b1", {24'd0, mem[8'h31]}, 32'h5A);
    check("rstmid_b2", {24'd0, mem[8'h32]}, 32'h5A);

    check("both_ready", 32'(both_cnt), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
